// File: rtl/roi_harness_pkg.sv
// Shared types and constants for the host-side ROI harness driver.
package roi_harness_pkg;

    // Run phases of the driver.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    localparam int DEF_DIN_N  = 256;
    localparam int DEF_DOUT_N = 256;

    // Cycles from start acceptance to the result_valid pulse.
    function automatic int run_latency(input int din_n, input int dout_n, input int do_lat);
        return 2 * din_n + do_lat + dout_n + 2;
    endfunction

endpackage

// File: rtl/roi_harness_driver_sipo.sv
// Serial-in parallel-out register for the harness `do` stream; first bit ends up as MSB.
module harness_sipo #(
    parameter int N = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         din,
    output logic [N-1:0] data_next
);

    logic [N-1:0] sh_reg;
    logic [N-1:0] shifted;

    generate
        if (N == 1) begin : g_one
            assign shifted = din;
        end else begin : g_many
            assign shifted = {sh_reg[N-2:0], din};
        end
    endgenerate

    // Value the register holds after this cycle; lets the owner publish the final bit without a bubble.
    assign data_next = shift_en ? shifted : sh_reg;

    // Shift in one bit per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_reg <= '0;
        end else begin
            sh_reg <= data_next;
        end
    end

endmodule

// File: rtl/roi_harness_driver.sv
// Drives the serial ROI harness: streams a stimulus word onto di, strobes twice, reads back do.
module roi_harness_driver
    import roi_harness_pkg::*;
#(
    parameter int DIN_N  = DEF_DIN_N,
    parameter int DOUT_N = DEF_DOUT_N,
    parameter int DO_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIN_N-1:0]  vec_in,
    output logic              ready,
    output logic [DOUT_N-1:0] result,
    output logic              result_valid,
    output logic              di_o,
    output logic              stb_o,
    input  logic              do_i
);

    localparam int MAXC = (DIN_N > DOUT_N + DO_LAT + 1) ? DIN_N : DOUT_N + DO_LAT + 1;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = $clog2(DIN_N);

    localparam logic [CW-1:0] LAST_DIN = CW'(DIN_N - 1);
    localparam logic [CW-1:0] LAST_CAP = CW'(DO_LAT + DOUT_N);
    localparam logic [CW-1:0] SKIP_CNT = CW'(DO_LAT);

    state_t            state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [DIN_N-1:0]  vec_q;
    logic [IW-1:0]     bit_idx;
    logic              shift_en;
    logic [DOUT_N-1:0] sh_next;

    // Outputs are registered, so the mux selects the bit for the following cycle (t+1).
    assign bit_idx  = IW'(DIN_N - 2) - cnt_reg[IW-1:0];

    // Bits arriving before DO_LAT+1 cycles into CAPTURE are still pipeline fill.
    assign shift_en = (state_reg == CAPTURE) && (cnt_reg > SKIP_CNT);

    harness_sipo #(.N(DOUT_N)) u_sipo (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .din       (do_i),
        .data_next (sh_next)
    );

    // Run sequencer with registered pin and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            vec_q        <= '0;
            ready        <= 1'b1;
            di_o         <= 1'b0;
            stb_o        <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            stb_o        <= 1'b0;
            result_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    di_o <= 1'b0;
                    if (start && ready) begin
                        vec_q     <= vec_in;
                        state_reg <= LOAD;
                        cnt_reg   <= '0;
                        ready     <= 1'b0;
                        di_o      <= vec_in[DIN_N-1];
                    end
                end
                LOAD: begin
                    if (cnt_reg == LAST_DIN) begin
                        // Stream rotates: first SETTLE cycle repeats the MSB and loads the ROI.
                        state_reg <= SETTLE;
                        cnt_reg   <= '0;
                        di_o      <= vec_q[DIN_N-1];
                        stb_o     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                        di_o    <= vec_q[bit_idx];
                    end
                end
                SETTLE: begin
                    if (cnt_reg == LAST_DIN) begin
                        // Harness register is back to vec_q: reload din and capture dout.
                        state_reg <= CAPTURE;
                        cnt_reg   <= '0;
                        di_o      <= 1'b0;
                        stb_o     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                        di_o    <= vec_q[bit_idx];
                    end
                end
                CAPTURE: begin
                    di_o <= 1'b0;
                    if (cnt_reg == LAST_CAP) begin
                        state_reg    <= DONE;
                        cnt_reg      <= '0;
                        result       <= sh_next;
                        result_valid <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    ready     <= 1'b1;
                    di_o      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    ready     <= 1'b1;
                    di_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_roi_harness_driver.sv
// Bench: three driver instances (8/8/0, 8/8/2, 256/256/0), each facing a behavioural harness.
module tb_roi_harness_driver;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        rst_p;
    logic [NI-1:0]        start_p;
    logic [NI-1:0][255:0] vec_p;
    logic [NI-1:0]        ready_p;
    logic [NI-1:0]        rv_p;
    logic [NI-1:0]        di_p;
    logic [NI-1:0]        stb_p;
    logic [NI-1:0][255:0] res_p;
    logic                 roi_not;

    int checks = 0;
    int errors = 0;

    function automatic int din_of(input int k);
        return (k == 2) ? 256 : 8;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_inst
            localparam int DN = (gi == 2) ? 256 : 8;
            localparam int LT = (gi == 1) ? 2 : 0;

            logic [DN-1:0] res_w;
            logic [DN-1:0] h_sr;
            logic [DN-1:0] h_din;
            logic [DN-1:0] h_dout;
            logic [7:0]    do_pipe;
            logic          do_w;

            roi_harness_driver #(.DIN_N(DN), .DOUT_N(DN), .DO_LAT(LT)) u_dut (
                .clk          (clk),
                .rst          (rst_p[gi]),
                .start        (start_p[gi]),
                .vec_in       (vec_p[gi][DN-1:0]),
                .ready        (ready_p[gi]),
                .result       (res_w),
                .result_valid (rv_p[gi]),
                .di_o         (di_p[gi]),
                .stb_o        (stb_p[gi]),
                .do_i         (do_w)
            );

            assign res_p[gi] = 256'(res_w);

            // Harness: di shift chain, stb latches din into the ROI and parallel-loads dout.
            always @(posedge clk) begin
                h_sr <= {h_sr[DN-2:0], di_p[gi]};
                if (stb_p[gi]) begin
                    h_din  <= h_sr;
                    h_dout <= roi_not ? ~h_din : h_din;
                end else begin
                    h_dout <= {h_dout[DN-2:0], 1'b0};
                end
                do_pipe <= {do_pipe[6:0], h_dout[DN-1]};
            end

            if (LT == 0) begin : g_direct
                assign do_w = h_dout[DN-1];
            end else begin : g_piped
                assign do_w = do_pipe[LT-1];
            end
        end
    endgenerate

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] roi_ref(input int k, input logic [255:0] v);
        logic [255:0] mask;
        mask = (din_of(k) == 256) ? {256{1'b1}} : ((256'd1 << din_of(k)) - 256'd1);
        return roi_not ? (~v & mask) : (v & mask);
    endfunction

    // One complete run on instance k, checking the pin waveform every cycle.
    task automatic run(input int k, input logic [255:0] v);
        int dn, lat, exp_t, seen;
        logic [255:0] expv;
        logic exp_di, exp_stb;
        dn    = din_of(k);
        lat   = lat_of(k);
        exp_t = 2 * dn + lat + dn + 1;
        expv  = roi_ref(k, v);
        seen  = 0;
        @(negedge clk);
        check_val("ready_idle", 256'(ready_p[k]), 256'd1);
        vec_p[k]   = v;
        start_p[k] = 1'b1;
        @(posedge clk);
        #1;
        start_p[k] = 1'b0;
        vec_p[k]   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int t = 0; t < 2000 && seen == 0; t++) begin
            exp_di  = (t < 2 * dn) ? v[dn-1-(t % dn)] : 1'b0;
            exp_stb = (t == dn) || (t == 2 * dn);
            check_val($sformatf("di_k%0d_t%0d", k, t), 256'(di_p[k]), 256'(exp_di));
            check_val($sformatf("stb_k%0d_t%0d", k, t), 256'(stb_p[k]), 256'(exp_stb));
            if (rv_p[k]) begin
                seen = 1;
                check_val("latency", 256'(t), 256'(exp_t));
                check_val("result", res_p[k], expv);
            end else begin
                check_val("ready_busy", 256'(ready_p[k]), 256'd0);
                @(posedge clk);
                #1;
            end
        end
        if (seen == 0) check_val("rv_timeout", 256'd0, 256'd1);
        @(posedge clk);
        #1;
        check_val("rv_one_cycle", 256'(rv_p[k]), 256'd0);
        check_val("ready_after", 256'(ready_p[k]), 256'd1);
        check_val("result_hold", res_p[k], expv);
        $display("run k=%0d vec=%h result=%h exp=%h", k, v, res_p[k], expv);
    endtask

    initial begin
        int c, done_c, acc, res_n, bad_rv, bad_rdy;
        logic [255:0] q[$];
        logic [255:0] nv;
        logic rdy;

        roi_not = 1'b0;
        rst_p   = '1;
        start_p = '0;
        vec_p   = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check_val("rst_ready", 256'(ready_p[k]), 256'd1);
            check_val("rst_di", 256'(di_p[k]), 256'd0);
            check_val("rst_stb", 256'(stb_p[k]), 256'd0);
            check_val("rst_rv", 256'(rv_p[k]), 256'd0);
            check_val("rst_result", res_p[k], 256'd0);
        end
        rst_p = '0;

        // Directed cases from the plan.
        roi_not = 1'b0; run(0, 256'hA5);
        roi_not = 1'b1; run(0, 256'h3C);
        roi_not = 1'b0; run(1, 256'h81);

        // Random small runs with random ROI polarity.
        for (int i = 0; i < 4; i++) begin
            roi_not = 1'($urandom_range(0, 1));
            run(0, 256'($urandom_range(0, 255)));
            run(1, 256'($urandom_range(0, 255)));
        end

        // Reset during SETTLE aborts the run.
        roi_not = 1'b0;
        @(negedge clk);
        vec_p[0]   = 256'hF0;
        start_p[0] = 1'b1;
        @(posedge clk);
        #1;
        start_p[0] = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        rst_p[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_p[0] = 1'b0;
        check_val("abort_ready", 256'(ready_p[0]), 256'd1);
        check_val("abort_stb", 256'(stb_p[0]), 256'd0);
        check_val("abort_di", 256'(di_p[0]), 256'd0);
        check_val("abort_rv", 256'(rv_p[0]), 256'd0);
        bad_rv  = 0;
        bad_rdy = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rv_p[0]) bad_rv++;
            if (!ready_p[0]) bad_rdy++;
        end
        check_val("abort_no_result", 256'(bad_rv), 256'd0);
        check_val("abort_stays_idle", 256'(bad_rdy), 256'd0);
        run(0, 256'h5A);

        // start held high, vec_in changing every cycle.
        roi_not = 1'b0;
        c = 0; done_c = -1; acc = 0; res_n = 0;
        @(negedge clk);
        start_p[0] = 1'b1;
        for (int i = 0; i < 200 && res_n < 2; i++) begin
            rdy      = ready_p[0];
            nv       = 256'($urandom_range(0, 255));
            vec_p[0] = nv;
            if (rdy) begin
                if (done_c >= 0) check_val("acc_after_done", 256'(c > done_c), 256'd1);
                q.push_back(nv);
                acc++;
                $display("hold accept cycle=%0d vec=%h", c, nv);
            end
            @(posedge clk);
            #1;
            c++;
            if (rv_p[0]) begin
                done_c = c;
                res_n++;
                if (q.size() == 0) check_val("rv_without_acc", 256'd0, 256'd1);
                else check_val("hold_result", res_p[0], q.pop_front());
                $display("hold result cycle=%0d result=%h", c, res_p[0]);
            end else begin
                @(negedge clk);
            end
        end
        start_p[0] = 1'b0;
        check_val("hold_results", 256'(res_n), 256'd2);
        check_val("hold_accepts", 256'(acc), 256'd2);

        // Default-size instance with random 256-bit words.
        for (int i = 0; i < 2; i++) begin
            run(2, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/roi_harness_driver.md
Name: roi_harness_driver

Overview:
- Host-side end of the serial ROI test harness.
- Takes a parallel stimulus word and shifts it onto the harness `di` pin, MSB first, as a rotating stream.
- Issues two `stb` pulses: the first loads the ROI inputs, the second captures the ROI outputs.
- Then deserialises the harness `do` pin back into a parallel result word with a valid pulse.
- Sits in bench and board-test wrappers, directly facing the harness `di`/`stb`/`do` pins.

Parameters:
- DIN_N, 256, harness input shift-chain length in bits; must be ≥2.
- DOUT_N, 256, harness output shift-chain length in bits; must be ≥1.
- DO_LAT, 0, extra register stages between the harness `do` and this block's `do_i`; range 0..7.

Ports:
- clk  in  1  sole clock, shared with the harness.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a run; accepted only when start && ready.
- vec_in  in  DIN_N  stimulus word; latched on acceptance.
- ready  out  1  high in IDLE only.
- result  out  DOUT_N  captured ROI outputs; holds until the next result_valid.
- result_valid  out  1  one-cycle pulse when result is updated.
- di_o  out  1  to harness `di`; registered.
- stb_o  out  1  to harness `stb`; registered.
- do_i  in  1  from harness `do`.

Behaviour:
- Reset (synchronous, any state):
  - The next cycle shows ready=1, di_o=0, stb_o=0, result_valid=0, result=0.
  - State goes to IDLE; all counters are cleared.
  - A run in progress is aborted; no partial result is published.
- States: IDLE, LOAD, SETTLE, CAPTURE, DONE.
- Time origin: t=0 is the first LOAD cycle, which is the cycle after acceptance. Port values are given for the cycle they are presented.
- IDLE:
  - di_o=0, stb_o=0.
  - On start && ready: latch vec_in into vec_q, then go to LOAD.
  - start while not ready is ignored; it is neither queued nor an error.
- LOAD, t=0..DIN_N-1:
  - di_o = vec_q[DIN_N-1-t].
  - stb_o=0.
- SETTLE, t=DIN_N..2*DIN_N-1:
  - di_o = vec_q[DIN_N-1-(t-DIN_N)], i.e. the stream rotates with period DIN_N.
  - stb_o=1 only at t=DIN_N. That strobe loads the ROI din, because the harness shift register equals vec_q at that cycle.
  - The remainder of SETTLE is the ROI settle window. By t=2*DIN_N the harness shift register again equals vec_q.
- CAPTURE, t=2*DIN_N .. 2*DIN_N+DO_LAT+DOUT_N:
  - stb_o=1 only at t=2*DIN_N. This reloads the identical din and captures dout.
  - di_o=0 throughout.
  - Sample bit j (0..DOUT_N-1) of do_i at t=2*DIN_N+1+DO_LAT+j into result_sh[DOUT_N-1-j]; the first bit received is the MSB.
- DONE, t=2*DIN_N+DO_LAT+DOUT_N+1:
  - result <= result_sh and result_valid=1 in this same cycle.
  - Next cycle returns to IDLE with ready=1.
- Latency: result_valid occurs at acceptance + 2*DIN_N+DO_LAT+DOUT_N+2 cycles. With default parameters this is 770.
- Back-to-back runs: start is accepted no earlier than the cycle after DONE. The next run's LOAD restarts the stream; the harness needs no flush.
- Counters:
  - One phase counter of width $clog2(max(DIN_N, DOUT_N+DO_LAT+1))+1.
  - It is compared, never wrapped through its full range.
  - It is reset to 0 on every state change.
- `do` is always sampled unconditionally; no X filtering is applied.

Decomposition:
- Package roi_harness_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, CAPTURE, DONE);
  - the default DIN_N/DOUT_N constants;
  - a function computing the run latency from (DIN_N, DOUT_N, DO_LAT) for benches.
- One natural sub-module: harness_sipo, a DOUT_N-bit serial-in shift register with a shift-enable.
- The parallel-to-serial side is a mux on vec_q indexed by the phase counter and stays in the top.

Test Plan:
- DIN_N=8, DOUT_N=8, DO_LAT=0; bench harness model with identity ROI (dout=din); vec_in=8'hA5 -> result=8'hA5, result_valid exactly at acceptance+26, stb_o high at t=8 and t=16 only.
- Same setup, ROI = bitwise NOT, vec_in=8'h3C -> result=8'hC3; di_o over t=0..7 is 0,0,1,1,1,1,0,0 and repeats over t=8..15.
- DO_LAT=2 with two pipeline flops inserted on `do`, vec_in=8'h81, identity ROI -> result=8'h81, result_valid at acceptance+28.
- rst asserted at t=12, during SETTLE -> next cycle ready=1, stb_o=0, di_o=0, no result_valid. A following run with 8'h5A then yields 8'h5A.
- start held high through a run with vec_in changing mid-run -> exactly one run per acceptance. Each result matches vec_in as latched at its own acceptance, and the second acceptance occurs no earlier than the cycle after DONE.
- Default parameters (256/256/0), random vec_in, identity ROI -> result == vec_in and result_valid at acceptance+770.
